// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: data width, ALU function codes, opcodes, FSM states.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package alu_pkg;

    localparam int DW = 4;

    localparam logic [1:0] ALU_ADD  = 2'd0;
    localparam logic [1:0] ALU_SUB  = 2'd1;
    localparam logic [1:0] ALU_DBL  = 2'd2;
    localparam logic [1:0] ALU_ZERO = 2'd3;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_LDI  = 3'd1,
        OP_ADDI = 3'd2,
        OP_SUBI = 3'd3,
        OP_DBL  = 3'd4,
        OP_CLR  = 3'd5,
        OP_STB  = 3'd6,
        OP_ADDB = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Ops whose result comes back through the external ALU
    function automatic logic is_alu_op(input op_t op);
        return (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_DBL) ||
               (op == OP_CLR)  || (op == OP_ADDB);
    endfunction

    // Ops that honour the repeat field; CLR is idempotent so it always runs once
    function automatic logic uses_rep(input op_t op);
        return (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_DBL) || (op == OP_ADDB);
    endfunction

endpackage

// File: rtl/alu_acc_seq.sv
// Command sequencer driving a 4-bit combinational ALU and accumulating its result.
// Latency: command accept to rsp_valid is rep+2 cycles for repeating ALU ops, 2 cycles otherwise.
// Backpressure: response held stable until rsp_ready; cmd_ready low from accept until the response is taken.
module alu_acc_seq
    import alu_pkg::*;
#(
    parameter int REP_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [DW-1:0]    cmd_imm,
    input  logic [REP_W-1:0] cmd_rep,
    output logic [DW-1:0]    alu_x,
    output logic [DW-1:0]    alu_y,
    output logic [1:0]       alu_f,
    input  logic [DW-1:0]    alu_xy,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DW-1:0]    rsp_acc,
    output logic             rsp_zero
);

    state_t             state_q, state_d;
    op_t                op_q;
    logic [DW-1:0]      imm_q;
    logic [DW-1:0]      acc_q;
    logic [DW-1:0]      b_q;
    logic [REP_W-1:0]   rep_q;

    // Next-state and output decode; ALU pins rest at X=0,Y=0,F=ZERO unless executing an ALU op
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        alu_x     = '0;
        alu_y     = '0;
        alu_f     = ALU_ZERO;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (is_alu_op(op_q)) begin
                    alu_x = acc_q;
                    case (op_q)
                        OP_ADDI: begin alu_f = ALU_ADD; alu_y = imm_q; end
                        OP_SUBI: begin alu_f = ALU_SUB; alu_y = imm_q; end
                        OP_DBL:  begin alu_f = ALU_DBL; alu_y = '0;    end
                        OP_ADDB: begin alu_f = ALU_ADD; alu_y = b_q;   end
                        default: begin alu_f = ALU_ZERO; alu_y = '0;   end
                    endcase
                end
                if (rep_q == '0) state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rsp_acc  = acc_q;
    assign rsp_zero = (acc_q == '0);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Command latch, repeat counter and accumulator/B register updates
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q  <= OP_NOP;
            imm_q <= '0;
            rep_q <= '0;
            acc_q <= '0;
            b_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q  <= op_t'(cmd_op);
                        imm_q <= cmd_imm;
                        rep_q <= uses_rep(op_t'(cmd_op)) ? cmd_rep : '0;
                    end
                end
                ST_EXEC: begin
                    if (is_alu_op(op_q))    acc_q <= alu_xy;
                    else if (op_q == OP_LDI) acc_q <= imm_q;
                    else if (op_q == OP_STB) b_q   <= imm_q;
                    if (rep_q != '0) rep_q <= rep_q - REP_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_acc_seq.sv
// Directed bench for alu_acc_seq with a behavioural ALU and a response scoreboard.
// Latency: checks accept-to-response cycle counts per command.
// Backpressure: exercises held responses and reset mid-execution.
module tb_alu_acc_seq;
    import alu_pkg::*;

    typedef struct packed {
        logic [3:0] acc;
        logic       zero;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_imm;
    logic [1:0] cmd_rep;
    logic [3:0] alu_x, alu_y, alu_xy;
    logic [1:0] alu_f;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_acc;
    logic       rsp_zero;

    int checks = 0;
    int errors = 0;

    exp_t       sb[$];
    logic [3:0] m_acc = 4'd0;
    logic [3:0] m_b   = 4'd0;

    logic [3:0] tx[16];
    logic [3:0] ty[16];
    logic [1:0] tf[16];
    int         ntr;

    always #5 clk = ~clk;

    // Reference 4-bit ALU feeding the sequencer
    always_comb begin
        case (alu_f)
            2'd0:    alu_xy = alu_x + alu_y;
            2'd1:    alu_xy = alu_x - alu_y;
            2'd2:    alu_xy = {alu_x[2:0], 1'b0};
            default: alu_xy = 4'd0;
        endcase
    end

    alu_acc_seq #(.REP_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_imm   (cmd_imm),
        .cmd_rep   (cmd_rep),
        .alu_x     (alu_x),
        .alu_y     (alu_y),
        .alu_f     (alu_f),
        .alu_xy    (alu_xy),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_acc   (rsp_acc),
        .rsp_zero  (rsp_zero)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input op_t op, input logic [3:0] imm, input logic [1:0] rep, input int hold);
        int   exp_lat;
        int   lat;
        logic got;
        exp_t e;
        case (op)
            OP_LDI:  m_acc = imm;
            OP_STB:  m_b = imm;
            OP_CLR:  m_acc = 4'd0;
            OP_ADDI: for (int i = 0; i <= int'(rep); i++) m_acc = m_acc + imm;
            OP_SUBI: for (int i = 0; i <= int'(rep); i++) m_acc = m_acc - imm;
            OP_DBL:  for (int i = 0; i <= int'(rep); i++) m_acc = m_acc << 1;
            OP_ADDB: for (int i = 0; i <= int'(rep); i++) m_acc = m_acc + m_b;
            default: ;
        endcase
        sb.push_back('{acc: m_acc, zero: (m_acc == 4'd0)});
        exp_lat = (op == OP_ADDI || op == OP_SUBI || op == OP_DBL || op == OP_ADDB) ? int'(rep) + 2 : 2;

        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_imm   = imm;
        cmd_rep   = rep;
        chk("cmd_ready_idle", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_imm   = 4'd0;
        cmd_rep   = 2'd0;

        ntr = 0;
        got = 1'b0;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                lat = c;
                break;
            end
            chk("cmd_ready_exec", cmd_ready, 0);
            if (ntr < 16) begin
                tx[ntr] = alu_x;
                ty[ntr] = alu_y;
                tf[ntr] = alu_f;
                ntr++;
            end
        end
        if (!got) begin
            chk("rsp_timeout", 0, 1);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        chk("latency", lat, exp_lat);
        e = sb.pop_front();
        chk("rsp_acc", rsp_acc, e.acc);
        chk("rsp_zero", rsp_zero, e.zero);
        chk("cmd_ready_resp", cmd_ready, 0);

        // Hold the response off while offering a competing command
        for (int h = 0; h < hold; h++) begin
            cmd_valid = 1'b1;
            cmd_op    = OP_LDI;
            cmd_imm   = 4'hf;
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_acc", rsp_acc, e.acc);
            chk("hold_zero", rsp_zero, e.zero);
            chk("hold_cmd_ready", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_imm   = 4'd0;
        if (hold > 0) begin
            @(negedge clk);
            chk("post_hold_cmd_ready", cmd_ready, 1);
            chk("post_hold_rsp_valid", rsp_valid, 0);
        end
    endtask

    initial begin
        logic seen;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_imm   = 4'd0;
        cmd_rep   = 2'd0;
        rsp_ready = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_alu_f", alu_f, 3);
        chk("rst_alu_x", alu_x, 0);
        chk("rst_alu_y", alu_y, 0);
        chk("rst_acc", rsp_acc, 0);
        chk("rst_zero", rsp_zero, 1);
        rst = 1'b0;

        // Load then add
        send(OP_LDI, 4'd5, 2'd0, 0);
        send(OP_ADDI, 4'd3, 2'd0, 0);

        // Wrapping subtract: 8 - 9 = 15
        send(OP_SUBI, 4'd9, 2'd0, 0);
        chk("subi_exec_cycles", ntr, 1);
        chk("subi_f", tf[0], 1);
        chk("subi_x", tx[0], 8);
        chk("subi_y", ty[0], 9);

        // Repeated doubling shifts the bit out: 1,2,4,8 -> 0
        send(OP_LDI, 4'd1, 2'd0, 0);
        send(OP_DBL, 4'd0, 2'd3, 0);
        chk("dbl_exec_cycles", ntr, 4);
        for (int i = 0; i < 4; i++) begin
            chk("dbl_x_seq", tx[i], 4'd1 << i);
            chk("dbl_f_seq", tf[i], 2);
        end

        // B register path and persistence
        send(OP_LDI, 4'd3, 2'd0, 0);
        send(OP_STB, 4'd7, 2'd0, 0);
        send(OP_ADDB, 4'd0, 2'd1, 0);
        send(OP_ADDB, 4'd0, 2'd0, 0);

        // Repeat field ignored for non-repeating ops
        send(OP_CLR, 4'd0, 2'd3, 0);
        chk("clr_f", tf[0], 3);
        send(OP_NOP, 4'd6, 2'd2, 0);
        send(OP_LDI, 4'd8, 2'd0, 0);

        // Response backpressure for 5 cycles
        send(OP_ADDI, 4'd1, 2'd0, 5);

        // Reset during the second EXEC cycle of a repeated add
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_ADDI;
        cmd_imm   = 4'd2;
        cmd_rep   = 2'd3;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_imm   = 4'd0;
        cmd_rep   = 2'd0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_alu_f", alu_f, 3);
        chk("abort_alu_x", alu_x, 0);
        chk("abort_alu_y", alu_y, 0);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_acc", rsp_acc, 0);
        @(posedge clk);
        @(negedge clk);
        rst   = 1'b0;
        m_acc = 4'd0;
        m_b   = 4'd0;
        seen  = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("abort_no_rsp", seen, 0);
        send(OP_NOP, 4'd0, 2'd0, 0);
        send(OP_LDI, 4'd2, 2'd0, 0);
        send(OP_ADDB, 4'd0, 2'd0, 0);

        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
